// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM encoding and PC-source priority decode for the IF stage.
package instruction_fetch_pkg;

  localparam int          PC_SIZE_DEF          = 32;
  localparam int          INSTRUCTION_SIZE_DEF = 32;
  localparam int          IMEM_DEPTH_DEF       = 256;
  localparam int          IMEM_ADDR_SIZE_DEF   = 8;
  localparam logic [31:0] NOP_INSTR            = 32'h0;

  typedef enum logic [1:0] {
    IF_IDLE   = 2'b00,
    IF_RUN    = 2'b01,
    IF_HALTED = 2'b10
  } if_state_e;

  typedef enum logic [2:0] {
    SEL_HALT,
    SEL_BRANCH,
    SEL_HOLD,
    SEL_JR,
    SEL_JUMP,
    SEL_SEQ
  } pc_sel_e;

  // The branch comes from MEM and is older than anything in ID, so it beats the stall.
  function automatic pc_sel_e pc_select(input logic halt, input logic branch,
                                        input logic stall, input logic jr,
                                        input logic jump);
    if (halt)        return SEL_HALT;
    else if (branch) return SEL_BRANCH;
    else if (stall)  return SEL_HOLD;
    else if (jr)     return SEL_JR;
    else if (jump)   return SEL_JUMP;
    else             return SEL_SEQ;
  endfunction

endpackage

// File: rtl/instruction_fetch_imem.sv
// Debug-loadable instruction memory: synchronous write, combinational read, no reset.
module instruction_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage + IF/ID register with load/run/halt FSM and redirect/stall handling.
// Optional IFETCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter on o_cycle_count.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE          = PC_SIZE_DEF,
  parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF,
  parameter int IMEM_DEPTH       = IMEM_DEPTH_DEF,
  parameter int IMEM_ADDR_SIZE   = IMEM_ADDR_SIZE_DEF
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_pipeline_enable,
  input  logic                        i_start,
  input  logic                        i_stall,
  input  logic                        i_halt,
  input  logic                        i_branch_taken,
  input  logic [PC_SIZE-1:0]          i_branch_addr,
  input  logic                        i_jump,
  input  logic [PC_SIZE-1:0]          i_jump_addr,
  input  logic                        i_jr_jalr,
  input  logic [PC_SIZE-1:0]          i_jr_addr,
  input  logic                        i_imem_wr_en,
  input  logic [IMEM_ADDR_SIZE-1:0]   i_imem_wr_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_imem_wr_data,
  output logic [INSTRUCTION_SIZE-1:0] o_inst,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic [PC_SIZE-1:0]          o_fetch_pc,
`ifdef IFETCH_CYCLE_COUNT_EN
  output logic [31:0]                 o_cycle_count,
`endif
  output logic [1:0]                  o_state
);

  localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(NOP_INSTR);

  if_state_e                   state_q, state_d;
  logic [PC_SIZE-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] inst_q, inst_d;
  logic [PC_SIZE-1:0]          npc_q, npc_d;
  logic [INSTRUCTION_SIZE-1:0] rd_data;
  pc_sel_e                     sel;

  // Loading is only legal before the program starts.
  instruction_memory #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (IMEM_ADDR_SIZE),
    .DATA_W (INSTRUCTION_SIZE)
  ) u_imem (
    .clk     (i_clock),
    .wr_en   (i_imem_wr_en && (state_q == IF_IDLE)),
    .wr_addr (i_imem_wr_addr),
    .wr_data (i_imem_wr_data),
    .rd_addr (pc_q[IMEM_ADDR_SIZE-1:0]),
    .rd_data (rd_data)
  );

  assign sel = pc_select(i_halt, i_branch_taken, i_stall, i_jr_jalr, i_jump);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    npc_d   = npc_q;
    if (i_pipeline_enable) begin
      unique case (state_q)
        IF_IDLE: begin
          pc_d   = '0;
          inst_d = NOP;
          npc_d  = '0;
          if (i_start) state_d = IF_RUN;
        end
        IF_RUN: begin
          unique case (sel)
            SEL_HALT: begin
              state_d = IF_HALTED;
              inst_d  = NOP;
              npc_d   = '0;
            end
            SEL_BRANCH: begin
              pc_d   = i_branch_addr;
              inst_d = NOP;
              npc_d  = '0;
            end
            SEL_HOLD: ;
            SEL_JR: begin
              pc_d   = i_jr_addr;
              inst_d = NOP;
              npc_d  = '0;
            end
            SEL_JUMP: begin
              pc_d   = i_jump_addr;
              inst_d = NOP;
              npc_d  = '0;
            end
            default: begin
              inst_d = rd_data;
              npc_d  = pc_q + PC_SIZE'(1);
              pc_d   = pc_q + PC_SIZE'(1);
            end
          endcase
        end
        IF_HALTED: begin
          inst_d = NOP;
          npc_d  = '0;
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IF_IDLE;
      pc_q    <= '0;
      inst_q  <= NOP;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      npc_q   <= npc_d;
    end
  end

`ifdef IFETCH_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_pipeline_enable && (state_q == IF_RUN) && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cycle_count = cnt_q;
`endif

  assign o_inst     = inst_q;
  assign o_pc       = npc_q;
  assign o_fetch_pc = pc_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, corner sequences, random vs model.
module tb_instruction_fetch;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_pipeline_enable, i_start, i_stall, i_halt;
  logic        i_branch_taken, i_jump, i_jr_jalr, i_imem_wr_en;
  logic [31:0] i_branch_addr, i_jump_addr, i_jr_addr, i_imem_wr_data;
  logic [7:0]  i_imem_wr_addr;
  logic [31:0] o_inst, o_pc, o_fetch_pc;
  logic [1:0]  o_state;
`ifdef IFETCH_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_pipeline_enable (i_pipeline_enable),
    .i_start           (i_start),
    .i_stall           (i_stall),
    .i_halt            (i_halt),
    .i_branch_taken    (i_branch_taken),
    .i_branch_addr     (i_branch_addr),
    .i_jump            (i_jump),
    .i_jump_addr       (i_jump_addr),
    .i_jr_jalr         (i_jr_jalr),
    .i_jr_addr         (i_jr_addr),
    .i_imem_wr_en      (i_imem_wr_en),
    .i_imem_wr_addr    (i_imem_wr_addr),
    .i_imem_wr_data    (i_imem_wr_data),
    .o_inst            (o_inst),
    .o_pc              (o_pc),
    .o_fetch_pc        (o_fetch_pc),
`ifdef IFETCH_CYCLE_COUNT_EN
    .o_cycle_count     (o_cycle_count),
`endif
    .o_state           (o_state)
  );

  always #5 i_clock = ~i_clock;

  // Reference model: architectural state tracked as plain variables.
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_HALT = 2;
  int          m_state;
  logic [31:0] m_pc, m_inst, m_opc, m_cnt;
  logic [31:0] m_mem [256];

  typedef struct {
    logic        en, start, stall, halt, br, jmp, jr;
    logic [31:0] br_a, j_a, jr_a;
    logic [31:0] e_inst, e_pc, e_fpc;
    logic [1:0]  e_st;
  } vec_t;

  function automatic vec_t mkv(logic en, logic start, logic stall, logic halt,
                               logic br, logic jmp, logic jr,
                               logic [31:0] br_a, logic [31:0] j_a, logic [31:0] jr_a,
                               logic [31:0] e_inst, logic [31:0] e_pc,
                               logic [31:0] e_fpc, logic [1:0] e_st);
    vec_t v;
    v.en = en; v.start = start; v.stall = stall; v.halt = halt;
    v.br = br; v.jmp = jmp; v.jr = jr;
    v.br_a = br_a; v.j_a = j_a; v.jr_a = jr_a;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_fpc = e_fpc; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    i_pipeline_enable = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_halt = 1'b0;
    i_branch_taken = 1'b0; i_jump = 1'b0; i_jr_jalr = 1'b0; i_imem_wr_en = 1'b0;
    i_branch_addr = '0; i_jump_addr = '0; i_jr_addr = '0;
    i_imem_wr_addr = '0; i_imem_wr_data = '0;
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_pc = '0; m_inst = '0; m_opc = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic [31:0] fetched, target;
    logic        redirect;
    fetched = m_mem[m_pc[7:0]];
    if (i_imem_wr_en && m_state == ST_IDLE) m_mem[i_imem_wr_addr] = i_imem_wr_data;
    if (!i_pipeline_enable) return;
    if (m_state == ST_RUN && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_state == ST_IDLE) begin
      if (i_start) m_state = ST_RUN;
    end else if (m_state == ST_RUN) begin
      redirect = 1'b1;
      target   = m_pc;
      if (i_halt) begin
        m_state = ST_HALT;
      end else if (i_branch_taken) target = i_branch_addr;
      else if (i_stall) redirect = 1'b0;
      else if (i_jr_jalr) target = i_jr_addr;
      else if (i_jump) target = i_jump_addr;
      else begin
        redirect = 1'b0;
        m_inst = fetched;
        m_opc  = m_pc + 1;
        m_pc   = m_pc + 1;
      end
      if (redirect) begin
        m_pc = target; m_inst = '0; m_opc = '0;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_inst"}, o_inst, m_inst);
    chk({tag, "_pc"}, o_pc, m_opc);
    chk({tag, "_fpc"}, o_fetch_pc, m_pc);
    chk({tag, "_state"}, {30'd0, o_state}, m_state);
`ifdef IFETCH_CYCLE_COUNT_EN
    chk({tag, "_cnt"}, o_cycle_count, m_cnt);
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge i_clock);
    #1;
    cmp_model(tag);
  endtask

  // Called just after an edge check: reset pulse lands mid-cycle and clears outputs at once.
  task automatic do_reset();
    #1 i_reset = 1'b0;
    #1;
    model_reset();
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_fpc", o_fetch_pc, 32'h0);
    chk("rst_state", {30'd0, o_state}, 32'd0);
    #1 i_reset = 1'b1;
  endtask

  vec_t tbl [16];

  initial begin
    i_reset = 1'b0;
    clr();
    do_reset();

    // Program load (writes go through even with the pipeline gated off).
    for (int a = 0; a < 256; a++) begin
      i_imem_wr_en      = 1'b1;
      i_imem_wr_addr    = 8'(a);
      i_imem_wr_data    = (a == 0) ? 32'h2001_0005 : (a == 1) ? 32'h2002_0007 :
                          (a == 2) ? 32'h0022_1820 : 32'h1000_0000 + 32'(a);
      i_pipeline_enable = (a % 5) != 0;
      step("load");
    end
    clr();

    tbl[0]  = mkv(1,1,0,0,0,0,0, 0,0,0,     32'h0,         0,     0,     2'd1);
    tbl[1]  = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h2001_0005, 1,     1,     2'd1);
    tbl[2]  = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h2002_0007, 2,     2,     2'd1);
    tbl[3]  = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h0022_1820, 3,     3,     2'd1);
    tbl[4]  = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h1000_0003, 4,     4,     2'd1);
    tbl[5]  = mkv(1,0,1,0,0,0,0, 0,0,0,     32'h1000_0003, 4,     4,     2'd1);
    tbl[6]  = mkv(1,0,1,0,0,0,0, 0,0,0,     32'h1000_0003, 4,     4,     2'd1);
    tbl[7]  = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h1000_0004, 5,     5,     2'd1);
    tbl[8]  = mkv(0,0,0,0,0,1,0, 0,'h40,0,  32'h1000_0004, 5,     5,     2'd1);
    tbl[9]  = mkv(1,0,0,0,0,1,0, 0,'h10,0,  32'h0,         0,     'h10,  2'd1);
    tbl[10] = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h1000_0010, 'h11,  'h11,  2'd1);
    tbl[11] = mkv(1,0,1,0,1,0,1, 'h20,0,'h30, 32'h0,       0,     'h20,  2'd1);
    tbl[12] = mkv(1,0,0,0,0,1,1, 0,'h10,'h30, 32'h0,       0,     'h30,  2'd1);
    tbl[13] = mkv(1,0,1,0,0,1,0, 0,'h50,0,  32'h0,         0,     'h30,  2'd1);
    tbl[14] = mkv(1,0,0,0,0,0,0, 0,0,0,     32'h1000_0030, 'h31,  'h31,  2'd1);
    tbl[15] = mkv(1,0,0,1,1,0,0, 'h20,0,0,  32'h0,         0,     'h31,  2'd2);

    for (int i = 0; i < 16; i++) begin
      i_pipeline_enable = tbl[i].en;  i_start = tbl[i].start; i_stall = tbl[i].stall;
      i_halt = tbl[i].halt; i_branch_taken = tbl[i].br; i_jump = tbl[i].jmp;
      i_jr_jalr = tbl[i].jr; i_branch_addr = tbl[i].br_a; i_jump_addr = tbl[i].j_a;
      i_jr_addr = tbl[i].jr_a;
      step($sformatf("v%0d_model", i));
      chk($sformatf("v%0d_inst", i), o_inst, tbl[i].e_inst);
      chk($sformatf("v%0d_pc", i), o_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_fpc", i), o_fetch_pc, tbl[i].e_fpc);
      chk($sformatf("v%0d_state", i), {30'd0, o_state}, {30'd0, tbl[i].e_st});
    end
    clr();

    // HALTED ignores redirects, start and memory writes.
    for (int k = 0; k < 10; k++) begin
      i_jump = 1'b1; i_jump_addr = 32'h77; i_start = 1'b1;
      i_branch_taken = k[0]; i_branch_addr = 32'h99;
      i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd3; i_imem_wr_data = 32'hDEAD_BEEF;
      step("halt_model");
      chk("halt_fpc", o_fetch_pc, 32'h31);
      chk("halt_inst", o_inst, 32'h0);
      chk("halt_state", {30'd0, o_state}, 32'd2);
    end
    clr();

    // Leave HALTED via reset, run a little, reset mid-RUN, then rerun the kept program.
    do_reset();
    i_start = 1'b1; step("rs_start"); i_start = 1'b0;
    step("rs_a"); step("rs_b");
    chk("midrun_state_before", {30'd0, o_state}, 32'd1);
    do_reset();
    i_start = 1'b1; step("rr_start"); i_start = 1'b0;
    step("rr0");
    chk("rerun_mem0", o_inst, 32'h2001_0005);
    step("rr1"); step("rr2"); step("rr3");
    chk("rerun_mem3", o_inst, 32'h1000_0003);
    chk("rerun_pc", o_pc, 32'h4);

    // Random stimulus against the model, with periodic reset and reload.
    for (int c = 0; c < 1500; c++) begin
      if (m_state == ST_HALT || (c % 200) == 199) begin
        clr();
        do_reset();
      end
      i_pipeline_enable = ($urandom_range(7) != 0);
      i_start        = (m_state == ST_IDLE) ? ($urandom_range(15) == 0) : $urandom_range(1);
      i_halt         = ($urandom_range(63) == 0);
      i_branch_taken = ($urandom_range(7) == 0);
      i_stall        = ($urandom_range(4) == 0);
      i_jr_jalr      = ($urandom_range(9) == 0);
      i_jump         = ($urandom_range(9) == 0);
      i_branch_addr  = $urandom();
      i_jump_addr    = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : $urandom();
      i_jr_addr      = $urandom();
      i_imem_wr_en   = ($urandom_range(1) == 0);
      i_imem_wr_addr = 8'($urandom());
      i_imem_wr_data = $urandom();
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
